video_pattern_gen: RTL and testbench
====================================

Name: video_pattern_gen

Overview:
- Source end of the parallel video stream carried on the `*_red/_green/_blue/_dv/_hs/_vs` bus.
- It generates raster timing plus a selectable test pattern, so the `hdmi_tx` path can be exercised without an HDMI input.
- Sits in the `rx_clk` (pixel clock) domain. It can drive either the `conv_filt` input or `hdmi_tx` directly.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (cycles)
- H_SYNC, 40, hsync width (cycles)
- H_BP, 220, horizontal back porch (cycles)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  generator enable
- pattern  in  2  pattern select: 0 colour bars, 1 gradient, 2 checkerboard, 3 moving box
- tx_red  out  8  red pixel
- tx_green  out  8  green pixel
- tx_blue  out  8  blue pixel
- tx_dv  out  1  active-video flag
- tx_hs  out  1  hsync
- tx_vs  out  1  vsync
- frame_start  out  1  one-cycle pulse accompanying the first active pixel of each frame

Behaviour:
- One clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - `h_cnt`, `v_cnt`, frame counter and box position are 0.
  - `tx_red/green/blue` = 0, `tx_dv` = 0, `frame_start` = 0.
  - `tx_hs` = ~HS_POL, `tx_vs` = ~VS_POL.
  - Latched pattern = 0.
- Counters:
  - `h_cnt` counts 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - At wrap, `v_cnt` increments over 0..V_TOT-1, where V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - Counter widths are clog2 of the totals.
- Line and frame order is active, front porch, sync, back porch.
  - hs active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. Edges are aligned to h_cnt = 0.
  - dv = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Latency: every output is registered. The outputs for counter state (h, v) appear exactly 1 cycle after the counters hold (h, v). All outputs are mutually aligned.
- RGB is forced to 0 whenever dv = 0.
- `frame_start` = 1 on the output cycle where h = 0 and v = 0.
- Pattern latch: `pattern` is sampled only when h_cnt = 0 and v_cnt = 0, so a change mid-frame takes effect on the next frame.
- Patterns:
  - 0, colour bars: BAR_W = H_ACTIVE/8 (integer division). idx = h/BAR_W, clamped to 7. Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 1, gradient: R = h[7:0], G = v[7:0], B = h[7:0] ^ v[7:0].
  - 2, checkerboard: 32x32 cells. White when h[5] ^ v[5], else black.
  - 3, moving box: black background with a 64x64 white box at (bx, by).
    - bx advances +4 per frame and wraps to 0 when bx+64 > H_ACTIVE.
    - by advances +2 per frame and wraps to 0 when by+64 > V_ACTIVE.
    - Positions update at the frame_start instant.
- Enable:
  - While `en` = 0, counters hold at 0 and outputs hold their reset values.
  - On `en` 0->1, generation begins at h = v = 0. The first output cycle carries frame_start.
  - Deasserting `en` mid-frame returns to the idle state on the next cycle.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). Generation restarts from (0, 0) on the first clock after release, if `en` = 1.

Decomposition:
- Shared package `video_pkg`:
  - Pattern-select constants `PAT_BARS`, `PAT_GRAD`, `PAT_CHECK`, `PAT_BOX`.
  - Colour-bar 24-bit constants.
  - Default 720p60 timing constants.
- Sub-module `video_timing_gen`: counters, hs, vs, dv, frame_start and `h_cnt`/`v_cnt` outputs. It is reusable by other sources.
- `video_pattern_gen` contains the pattern mux, the box state and the output registers.

Test Plan:
- Reset behaviour: assert rst mid-line with small parameters (H 16/2/3/3, V 8/1/2/1) -> outputs at reset values, hs = vs = inactive. After release with en = 1, frame_start is seen 1 cycle later.
- Timing with default parameters:
  - Every line has 1650 clocks between hs rising edges.
  - hs is high for 40 clocks.
  - dv is high for 1280 clocks per active line.
  - 720 dv lines per frame.
  - vs is high for 5 lines.
  - frame_start period is 1,237,500 clocks.
- Colour bars, pattern = 0, default params -> active pixel 0 = FFFFFF, 160 = FFFF00, 800 = FF0000, 1279 = 000000. Blanking pixels = 000000.
- Pattern latch: switch pattern 0 -> 2 at line 100 -> rest of frame stays bars. Next frame pixel (32, 0) = FFFFFF and (0, 0) = 000000.
- Moving box: pattern = 3 for 3 frames -> frame 2 has white at (8, 4) through (71, 67) and black at (7, 4).
- Enable: drop en mid-line, raise it 10 clocks later -> dv/hs/vs idle in between. Restart with frame_start and h = 0.

Source files
------------

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared constants for the parallel video stream sources
package video_pkg;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_GRAD  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_BOX   = 2'd3;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  // 1280x720p60 raster
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  localparam int BOX_SIZE   = 64;
  localparam int BOX_STEP_X = 4;
  localparam int BOX_STEP_Y = 2;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster counters with registered dv/hs/vs/frame_start
module video_timing_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  localparam int  H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW       = $clog2(H_TOT),
  localparam int  VW       = $clog2(V_TOT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          dv,
  output logic          hs,
  output logic          vs,
  output logic          frame_start
);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYN_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYN_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYN_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYN_E = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Flags are registered from the current count so they trail it by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      dv          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      frame_start <= 1'b0;
    end else if (!en) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      dv          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      dv          <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs          <= (h_cnt >= H_SYN_S && h_cnt < H_SYN_E) ? HS_POL : ~HS_POL;
      vs          <= (v_cnt >= V_SYN_S && v_cnt < V_SYN_E) ? VS_POL : ~VS_POL;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - test-pattern source driving the tx video bus
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pattern,
  output logic [7:0] tx_red,
  output logic [7:0] tx_green,
  output logic [7:0] tx_blue,
  output logic       tx_dv,
  output logic       tx_hs,
  output logic       tx_vs,
  output logic       frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int BAR_W = H_ACTIVE / 8;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .dv          (tx_dv),
    .hs          (tx_hs),
    .vs          (tx_vs),
    .frame_start (frame_start)
  );

  logic [1:0]    pat_q;
  logic [HW-1:0] bx_q, bx_next, bx_cur;
  logic [VW-1:0] by_q, by_next, by_cur;
  logic          box_armed;
  logic          at_origin;
  logic          active;
  logic          in_box;
  logic [1:0]    pat_cur;
  logic [7:0]    h8, v8;
  logic [31:0]   bar_idx;
  logic [23:0]   rgb_next;

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign active    = (32'(h_cnt) < 32'(H_ACTIVE)) && (32'(v_cnt) < 32'(V_ACTIVE));

  // The origin pixel already belongs to the new frame, so it sees the fresh pattern and box
  assign pat_cur = at_origin ? pattern : pat_q;
  assign bx_next = (32'(bx_q) + 32'(BOX_STEP_X + BOX_SIZE) > 32'(H_ACTIVE)) ? '0 : bx_q + HW'(BOX_STEP_X);
  assign by_next = (32'(by_q) + 32'(BOX_STEP_Y + BOX_SIZE) > 32'(V_ACTIVE)) ? '0 : by_q + VW'(BOX_STEP_Y);
  assign bx_cur  = (at_origin && box_armed) ? bx_next : bx_q;
  assign by_cur  = (at_origin && box_armed) ? by_next : by_q;

  assign h8      = 8'(h_cnt);
  assign v8      = 8'(v_cnt);
  assign bar_idx = 32'(h_cnt) / 32'(BAR_W);
  assign in_box  = (32'(h_cnt) >= 32'(bx_cur)) && (32'(h_cnt) < 32'(bx_cur) + 32'(BOX_SIZE)) &&
                   (32'(v_cnt) >= 32'(by_cur)) && (32'(v_cnt) < 32'(by_cur) + 32'(BOX_SIZE));

  always_comb begin
    rgb_next = COL_BLACK;
    case (pat_cur)
      PAT_BARS:  rgb_next = bar_colour((bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0]);
      PAT_GRAD:  rgb_next = {h8, v8, h8 ^ v8};
      PAT_CHECK: rgb_next = (h8[5] ^ v8[5]) ? COL_WHITE : COL_BLACK;
      default:   rgb_next = in_box ? COL_WHITE : COL_BLACK;
    endcase
    if (!active) rgb_next = COL_BLACK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {tx_red, tx_green, tx_blue} <= COL_BLACK;
      pat_q     <= PAT_BARS;
      bx_q      <= '0;
      by_q      <= '0;
      box_armed <= 1'b0;
    end else if (!en) begin
      {tx_red, tx_green, tx_blue} <= COL_BLACK;
      pat_q     <= PAT_BARS;
      bx_q      <= '0;
      by_q      <= '0;
      box_armed <= 1'b0;
    end else begin
      {tx_red, tx_green, tx_blue} <= rgb_next;
      if (at_origin) begin
        pat_q     <= pattern;
        box_armed <= 1'b1;
        bx_q      <= bx_cur;
        by_q      <= by_cur;
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - randomized bench against a frame-level reference model
module tb_video_pattern_gen;

  localparam int   HA = 96, HF = 2, HSY = 4, HB = 2;
  localparam int   VA = 72, VF = 1, VSY = 2, VB = 1;
  localparam logic HS_POL = 1'b1;
  localparam logic VS_POL = 1'b0;
  localparam int   H_TOT = HA + HF + HSY + HB;
  localparam int   V_TOT = VA + VF + VSY + VB;
  localparam int   FT = H_TOT * V_TOT;
  localparam logic [27:0] IDLE = {24'h0, 1'b0, ~HS_POL, ~VS_POL, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic [7:0] tx_red, tx_green, tx_blue;
  logic tx_dv, tx_hs, tx_vs, frame_start;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  int last_t = 0;
  logic [1:0] cur_pat = 2'd0;
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern(pattern),
    .tx_red(tx_red), .tx_green(tx_green), .tx_blue(tx_blue),
    .tx_dv(tx_dv), .tx_hs(tx_hs), .tx_vs(tx_vs), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Expected {rgb, dv, hs, vs, frame_start} for raster index tt since generation began
  function automatic logic [27:0] model(input int tt, input logic [1:0] pat);
    int f, p, h, v, bx, by, idx;
    logic dv, hs, vs, fs;
    logic [23:0] rgb;
    logic [7:0] h8, v8;
    f = tt / FT;
    p = tt % FT;
    h = p % H_TOT;
    v = p / H_TOT;
    dv = (h < HA) && (v < VA);
    hs = (h >= HA + HF && h < HA + HF + HSY) ? HS_POL : ~HS_POL;
    vs = (v >= VA + VF && v < VA + VF + VSY) ? VS_POL : ~VS_POL;
    fs = (p == 0);
    h8 = h[7:0];
    v8 = v[7:0];
    bx = 0;
    by = 0;
    for (int i = 0; i < f; i++) begin
      bx = bx + 4;
      if (bx + 64 > HA) bx = 0;
      by = by + 2;
      if (by + 64 > VA) by = 0;
    end
    rgb = 24'h0;
    if (dv) begin
      case (pat)
        2'd0: begin
          idx = h / (HA / 8);
          if (idx > 7) idx = 7;
          rgb = bar_tab[idx];
        end
        2'd1: rgb = {h8, v8, h8 ^ v8};
        2'd2: rgb = (((h / 32) + (v / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
        default: rgb = (h >= bx && h < bx + 64 && v >= by && v < by + 64) ? 24'hFFFFFF : 24'h0;
      endcase
    end
    return {rgb, dv, hs, vs, fs};
  endfunction

  task automatic step();
    logic [27:0] got, exp;
    @(posedge clk);
    if (en && !rst && (t % FT == 0)) cur_pat = pattern;
    #1;
    got = {tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs, frame_start};
    exp = (en && !rst) ? model(t, cur_pat) : IDLE;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL stream t=%0d got=%h expected=%h", t, got, exp);
    end
    last_t = t;
    t = (en && !rst) ? t + 1 : 0;
  endtask

  task automatic restart();
    en = 1'b0;
    step();
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    pattern = 2'd0;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (frame_start !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_fs got=%b expected=1", frame_start);
    end
    repeat (40) step();
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs, frame_start} !== IDLE) begin
      n_bad++;
      $display("FAIL reset_async got=%h expected=%h",
               {tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs, frame_start}, IDLE);
    end
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (frame_start !== 1'b1 || tx_dv !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_restart got fs=%b dv=%b expected fs=1 dv=1", frame_start, tx_dv);
    end
    repeat (20) step();
  endtask

  task automatic test_bars();
    logic [23:0] rgb;
    restart();
    pattern = 2'd0;
    for (int i = 0; i < FT; i++) begin
      step();
      rgb = {tx_red, tx_green, tx_blue};
      if (last_t == 0 || last_t == 12 || last_t == 60 || last_t == 95 || last_t == 100) begin
        n_cmp++;
        if (rgb !== ((last_t == 0) ? 24'hFFFFFF : (last_t == 12) ? 24'hFFFF00 :
                     (last_t == 60) ? 24'hFF0000 : 24'h000000)) begin
          n_bad++;
          $display("FAIL bars_pixel h=%0d got=%h", last_t, rgb);
        end
      end
    end
  endtask

  task automatic test_latch();
    int sw_line, sw;
    restart();
    pattern = 2'd0;
    sw_line = $urandom_range(10, 60);
    sw = sw_line * H_TOT + $urandom_range(0, H_TOT - 1);
    for (int i = 0; i < 2 * FT; i++) begin
      if (i == sw) pattern = 2'd2;
      step();
      if (last_t == (sw_line + 1) * H_TOT + 12) begin
        n_cmp++;
        if ({tx_red, tx_green, tx_blue} !== 24'hFFFF00) begin
          n_bad++;
          $display("FAIL latch_hold got=%h expected=ffff00", {tx_red, tx_green, tx_blue});
        end
      end
      if (last_t == FT || last_t == FT + 32) begin
        n_cmp++;
        if ({tx_red, tx_green, tx_blue} !== ((last_t == FT) ? 24'h000000 : 24'hFFFFFF)) begin
          n_bad++;
          $display("FAIL latch_next t=%0d got=%h", last_t, {tx_red, tx_green, tx_blue});
        end
      end
    end
  endtask

  task automatic test_box();
    int base;
    restart();
    pattern = 2'd3;
    base = 2 * FT;
    for (int i = 0; i < 6 * FT; i++) begin
      step();
      if (last_t == base + 4 * H_TOT + 8 || last_t == base + 67 * H_TOT + 71) begin
        n_cmp++;
        if ({tx_red, tx_green, tx_blue} !== 24'hFFFFFF) begin
          n_bad++;
          $display("FAIL box_inside t=%0d got=%h expected=ffffff", last_t, {tx_red, tx_green, tx_blue});
        end
      end
      if (last_t == base + 4 * H_TOT + 7 || last_t == base + 67 * H_TOT + 72) begin
        n_cmp++;
        if ({tx_red, tx_green, tx_blue} !== 24'h000000) begin
          n_bad++;
          $display("FAIL box_outside t=%0d got=%h expected=000000", last_t, {tx_red, tx_green, tx_blue});
        end
      end
    end
  endtask

  task automatic test_enable();
    int n1;
    restart();
    pattern = 2'($urandom_range(0, 3));
    n1 = $urandom_range(150, 400);
    repeat (n1) step();
    en = 1'b0;
    repeat (10) step();
    pattern = 2'($urandom_range(0, 3));
    en = 1'b1;
    step();
    n_cmp++;
    if (frame_start !== 1'b1) begin
      n_bad++;
      $display("FAIL enable_restart_fs got=%b expected=1", frame_start);
    end
    repeat (200) step();
  endtask

  initial begin
    test_reset();
    test_bars();
    test_latch();
    test_box();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
